// File: rtl/maze_navigator_pkg.sv
// maze_navigator_pkg: motor/choice codes, FSM states and tracker patterns for the maze navigator.
package maze_navigator_pkg;
    typedef enum logic [2:0] {M_STOP = 3'd0, M_FWD = 3'd1, M_LEFT = 3'd2, M_RIGHT = 3'd3, M_SPIN = 3'd4} mode_t;
    typedef enum logic [1:0] {C_L = 2'd0, C_S = 2'd1, C_R = 2'd2} choice_t;
    typedef enum logic [2:0] {S_IDLE, S_FOLLOW, S_JCONF, S_DECIDE, S_TURN, S_UTURN, S_DONE, S_FAULT} state_t;
    localparam logic [2:0] D_NONE = 3'b000;
    localparam logic [2:0] D_ALL = 3'b111;
    localparam logic [2:0] D_BAD = 3'b101;
    function automatic mode_t follow_mode(input logic [2:0] d);
        return (d == 3'b110 || d == 3'b100) ? M_LEFT :
               (d == 3'b011 || d == 3'b001) ? M_RIGHT : M_FWD;
    endfunction
endpackage

// File: rtl/maze_navigator_if.sv
// maze_navigator_if: sensor inputs and motor/status outputs of the navigator.
interface maze_navigator_if #(parameter int DEPTH = 16);
    localparam int DW = $clog2(DEPTH + 1);
    logic enable;
    logic [2:0] detect;
    logic obstacle;
    logic [2:0] mode;
    logic [DW-1:0] depth;
    logic backtrack;
    logic done;
    logic fault;
    modport master (output enable, detect, obstacle, input mode, depth, backtrack, done, fault);
    modport slave (input enable, detect, obstacle, output mode, depth, backtrack, done, fault);
endinterface

// File: rtl/maze_navigator_decision_stack.sv
// decision_stack: LIFO of junction choices with push, pop and replace-top.
module decision_stack #(
    parameter int DEPTH = 16,
    parameter int W = 2,
    localparam int DW = $clog2(DEPTH + 1),
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic push,
    input  logic pop,
    input  logic replace,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic [DW-1:0] depth,
    output logic full,
    output logic empty
);
    logic [W-1:0] mem [DEPTH];
    assign full = depth == DW'(DEPTH);
    assign empty = depth == '0;
    assign top = empty ? '0 : mem[IW'(depth - 1'b1)];
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            depth <= '0;
        end else if (push && !full) begin
            mem[IW'(depth)] <= din;
            depth <= depth + 1'b1;
        end else if (pop && !empty) begin
            depth <= depth - 1'b1;
        end else if (replace && !empty) begin
            mem[IW'(depth - 1'b1)] <= din;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && !clear) begin
            assert (!(push && full));
            assert (!((pop || replace) && empty));
            assert ($onehot0({push, pop, replace}));
        end
    end
endmodule

// File: rtl/maze_navigator.sv
// maze_navigator: left-first DFS junction controller driving the motor mode with a choice stack.
module maze_navigator
    import maze_navigator_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int SETTLE_CYC = 5_000_000,
    parameter int GOAL_CYC = 40_000_000,
    parameter int TURN_CYC = 25_000_000,
    parameter int UTURN_CYC = 60_000_000
) (
    input logic clk,
    input logic rst,
    maze_navigator_if.slave nav
);
    state_t state;
    logic [31:0] cnt;
    logic push, pop, replace, full, empty;
    logic [1:0] top, din;
    // A retreat re-enters the junction from the branch just tried, so the next option is always left.
    assign push = state == S_DECIDE && !nav.backtrack && !full;
    assign replace = state == S_DECIDE && nav.backtrack && !empty && top != C_R;
    assign pop = state == S_DECIDE && nav.backtrack && !empty && top == C_R;
    assign din = nav.backtrack ? top + 2'd1 : C_L;
    decision_stack #(.DEPTH(DEPTH), .W(2)) stack (
        .clk(clk), .rst(rst), .clear(!nav.enable),
        .push(push), .pop(pop), .replace(replace), .din(din),
        .top(top), .depth(nav.depth), .full(full), .empty(empty)
    );
    always_ff @(posedge clk) begin
        if (rst || !nav.enable) begin
            state <= S_IDLE;
            nav.mode <= M_STOP;
            nav.backtrack <= 1'b0;
            nav.done <= 1'b0;
            nav.fault <= 1'b0;
            cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_FOLLOW;
                    nav.mode <= M_STOP;
                end
                S_FOLLOW: begin
                    if (nav.obstacle || nav.detect == D_NONE) begin
                        state <= S_UTURN;
                        nav.mode <= M_SPIN;
                        nav.backtrack <= 1'b1;
                        cnt <= '0;
                    end else if (nav.detect == D_ALL) begin
                        state <= S_JCONF;
                        nav.mode <= M_FWD;
                        cnt <= 32'd1;
                    end else if (nav.detect == D_BAD) begin
                        state <= S_FAULT;
                        nav.mode <= M_STOP;
                        nav.fault <= 1'b1;
                    end else begin
                        nav.mode <= follow_mode(nav.detect);
                    end
                end
                S_JCONF: begin
                    nav.mode <= M_FWD;
                    if (nav.detect == D_ALL) begin
                        cnt <= cnt + 32'd1;
                        if (cnt >= 32'(GOAL_CYC - 1)) begin
                            state <= S_DONE;
                            nav.mode <= M_STOP;
                            nav.done <= 1'b1;
                        end
                    end else begin
                        state <= cnt >= 32'(SETTLE_CYC) ? S_DECIDE : S_FOLLOW;
                    end
                end
                S_DECIDE: begin
                    cnt <= '0;
                    if (nav.backtrack ? empty : full) begin
                        state <= S_FAULT;
                        nav.mode <= M_STOP;
                        nav.fault <= 1'b1;
                    end else begin
                        state <= S_TURN;
                        nav.mode <= M_LEFT;
                        if (nav.backtrack && top != C_R) nav.backtrack <= 1'b0;
                    end
                end
                S_TURN, S_UTURN: begin
                    if (cnt >= 32'((state == S_TURN ? TURN_CYC : UTURN_CYC) - 1)) begin
                        state <= S_FOLLOW;
                        nav.mode <= M_FWD;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: nav.mode <= M_STOP;
            endcase
        end
    end
endmodule

// File: tb/tb_maze_navigator.sv
// tb_maze_navigator: directed scoreboard bench for maze_navigator with shortened timings.
module tb_maze_navigator;
    import maze_navigator_pkg::*;
    typedef logic [7:0] exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    logic [1:0] md = 2'd0;
    logic mb = 1'b0;
    exp_t sb[$];
    string tags[$];
    maze_navigator_if #(.DEPTH(2)) nav ();
    maze_navigator #(.DEPTH(2), .SETTLE_CYC(4), .GOAL_CYC(20), .TURN_CYC(3), .UTURN_CYC(5))
        dut (.clk(clk), .rst(rst), .nav(nav));
    always #5 clk = ~clk;

    task automatic step(input logic e, input logic [2:0] d, input logic o,
                        input logic [2:0] m, input logic dn, input logic f, input string tag);
        exp_t want, got;
        string t;
        nav.enable = e;
        nav.detect = d;
        nav.obstacle = o;
        sb.push_back({m, md, mb, dn, f});
        tags.push_back(tag);
        @(posedge clk);
        #1;
        want = sb.pop_front();
        t = tags.pop_front();
        got = {nav.mode, nav.depth, nav.backtrack, nav.done, nav.fault};
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed {mode,depth,bt,done,fault}=%b expected %b", t, got, want);
        end
    endtask

    task automatic hold(input int n, input logic [2:0] m, input string tag);
        for (int i = 0; i < n; i++) step(1'b1, 3'b010, 1'b0, m, 1'b0, 1'b0, tag);
    endtask

    task automatic junction(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b1, 3'b111, 1'b0, M_FWD, 1'b0, 1'b0, tag);
        step(1'b1, 3'b010, 1'b0, M_FWD, 1'b0, 1'b0, tag);
    endtask

    task automatic turn(input string tag);
        step(1'b1, 3'b010, 1'b0, M_LEFT, 1'b0, 1'b0, tag);
        hold(2, M_LEFT, tag);
        hold(1, M_FWD, tag);
    endtask

    task automatic dead_end(input string tag);
        mb = 1'b1;
        step(1'b1, 3'b000, 1'b0, M_SPIN, 1'b0, 1'b0, tag);
        hold(4, M_SPIN, tag);
        hold(1, M_FWD, tag);
    endtask

    task automatic disable_run(input string tag);
        md = 2'd0;
        mb = 1'b0;
        step(1'b0, 3'b010, 1'b0, M_STOP, 1'b0, 1'b0, tag);
    endtask

    initial begin
        step(1'b0, 3'b010, 1'b0, M_STOP, 1'b0, 1'b0, "reset");
        rst = 1'b0;
        step(1'b1, 3'b010, 1'b0, M_STOP, 1'b0, 1'b0, "idle_exit");
        step(1'b1, 3'b010, 1'b0, M_FWD, 1'b0, 1'b0, "fwd_010");
        step(1'b1, 3'b110, 1'b0, M_LEFT, 1'b0, 1'b0, "left_110");
        step(1'b1, 3'b100, 1'b0, M_LEFT, 1'b0, 1'b0, "left_100");
        step(1'b1, 3'b011, 1'b0, M_RIGHT, 1'b0, 1'b0, "right_011");
        step(1'b1, 3'b001, 1'b0, M_RIGHT, 1'b0, 1'b0, "right_001");
        hold(1, M_FWD, "fwd_again");
        junction(2, "glitch2");
        hold(1, M_FWD, "glitch2_no_push");
        junction(3, "glitch3");
        hold(1, M_FWD, "glitch3_no_push");
        junction(6, "jconf");
        md = 2'd1;
        turn("push_left");
        dead_end("dead_end_1");
        junction(6, "revisit_1");
        mb = 1'b0;
        turn("top_to_s");
        dead_end("dead_end_2");
        junction(6, "revisit_2");
        mb = 1'b0;
        turn("top_to_r");
        dead_end("dead_end_3");
        junction(6, "revisit_3");
        md = 2'd0;
        turn("pop_keep_bt");
        junction(6, "revisit_root");
        step(1'b1, 3'b010, 1'b0, M_STOP, 1'b0, 1'b1, "exhausted");
        step(1'b1, 3'b010, 1'b0, M_STOP, 1'b0, 1'b1, "fault_sticky");
        disable_run("fault_clear");
        step(1'b1, 3'b111, 1'b0, M_STOP, 1'b0, 1'b0, "idle_exit");
        for (int i = 0; i < 19; i++) step(1'b1, 3'b111, 1'b0, M_FWD, 1'b0, 1'b0, "goal_wait");
        step(1'b1, 3'b111, 1'b0, M_STOP, 1'b1, 1'b0, "goal");
        step(1'b1, 3'b010, 1'b0, M_STOP, 1'b1, 1'b0, "done_sticky");
        disable_run("done_clear");
        step(1'b1, 3'b010, 1'b0, M_STOP, 1'b0, 1'b0, "idle_exit");
        mb = 1'b1;
        step(1'b1, 3'b111, 1'b1, M_SPIN, 1'b0, 1'b0, "obstacle_wins");
        hold(4, M_SPIN, "obstacle_uturn");
        hold(1, M_FWD, "obstacle_exit");
        disable_run("obstacle_clear");
        step(1'b1, 3'b010, 1'b0, M_STOP, 1'b0, 1'b0, "idle_exit");
        step(1'b1, 3'b101, 1'b0, M_STOP, 1'b0, 1'b1, "pattern_101");
        disable_run("pattern_clear");
        step(1'b1, 3'b010, 1'b0, M_STOP, 1'b0, 1'b0, "idle_exit");
        junction(4, "settle_edge");
        md = 2'd1;
        turn("push_1");
        junction(6, "jconf_2");
        md = 2'd2;
        turn("push_2");
        junction(6, "jconf_3");
        step(1'b1, 3'b010, 1'b0, M_STOP, 1'b0, 1'b1, "overflow");
        disable_run("overflow_clear");
        step(1'b1, 3'b010, 1'b0, M_STOP, 1'b0, 1'b0, "idle_exit");
        junction(6, "jconf_rst");
        md = 2'd1;
        step(1'b1, 3'b010, 1'b0, M_LEFT, 1'b0, 1'b0, "turn_rst");
        rst = 1'b1;
        md = 2'd0;
        step(1'b1, 3'b010, 1'b0, M_STOP, 1'b0, 1'b0, "rst_mid_turn");
        rst = 1'b0;
        step(1'b1, 3'b010, 1'b0, M_STOP, 1'b0, 1'b0, "after_rst");
        step(1'b1, 3'b010, 1'b0, M_FWD, 1'b0, 1'b0, "after_rst_fwd");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
